// File: rtl/s2p_link_controller.sv
// Round-robin frame scheduler that serializes 15-bit words (plus a leading pad bit)
// onto the clock/data/reset link of a downstream 15-bit serial-to-parallel register.
module s2p_link_controller #(
  parameter int NUM_REQ     = 2,
  parameter int CLK_DIV     = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int SYNC_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [15*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   serial_clock_out,
  output logic                   serial_data_out,
  output logic                   link_reset,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int SW = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV / 2 - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_CYCLES - 1);

  typedef enum logic [1:0] {SYNC, IDLE, SHIFT, GAP} state_t;

  state_t          state;
  logic [2:0]      rr_ptr;
  logic [PW-1:0]   phase_cnt;
  logic [3:0]      bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [SW-1:0]   sync_cnt;
  logic [14:0]     shreg;

  logic [2:0]      pick, pick_hi, pick_lo, next_ptr;
  logic            found_hi, any_valid;
  logic [14:0]     pick_word;

  // Arbitration: lowest valid index at/above the pointer, else lowest valid overall.
  always_comb begin
    pick_hi   = '0;
    pick_lo   = '0;
    found_hi  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_lo = 3'(i);
        if (3'(i) >= rr_ptr) begin
          pick_hi  = 3'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick     = found_hi ? pick_hi : pick_lo;
    next_ptr = (pick == 3'(NUM_REQ - 1)) ? 3'd0 : pick + 3'd1;
    pick_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == pick) pick_word = req_data[15*i +: 15];
    end
  end

  assign any_valid = |req_valid;

  // Control and registered link outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= SYNC;
      rr_ptr           <= '0;
      phase_cnt        <= '0;
      bit_cnt          <= '0;
      gap_cnt          <= '0;
      sync_cnt         <= '0;
      req_ready        <= '0;
      serial_clock_out <= 1'b0;
      serial_data_out  <= 1'b0;
      link_reset       <= 1'b1;
      busy             <= 1'b1;
      grant_id         <= '0;
      frame_done       <= 1'b0;
    end else begin
      req_ready  <= '0;
      frame_done <= 1'b0;
      case (state)
        SYNC: begin
          if (sync_cnt == SYNC_LAST) begin
            link_reset <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            sync_cnt <= sync_cnt + SW'(1);
          end
        end
        IDLE: begin
          if (any_valid) begin
            req_ready        <= NUM_REQ'(1) << pick;
            grant_id         <= pick;
            rr_ptr           <= next_ptr;
            busy             <= 1'b1;
            bit_cnt          <= '0;
            phase_cnt        <= '0;
            serial_clock_out <= 1'b0;
            serial_data_out  <= 1'b0;  // pad bit leads every frame
            state            <= SHIFT;
          end
        end
        SHIFT: begin
          if (phase_cnt == PH_LAST) begin
            phase_cnt        <= '0;
            serial_clock_out <= 1'b0;
            if (bit_cnt == 4'd15) begin
              serial_data_out <= 1'b0;
              gap_cnt         <= '0;
              state           <= GAP;
            end else begin
              bit_cnt         <= bit_cnt + 4'd1;
              serial_data_out <= shreg[14];
            end
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
            if (phase_cnt == PH_RISE) begin
              serial_clock_out <= 1'b1;
              if (bit_cnt == 4'd15) frame_done <= 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  // Word holding register: loaded on accept, shifted MSB-first at each bit boundary.
  always_ff @(posedge clock) begin
    if (state == IDLE && any_valid) begin
      shreg <= pick_word;
    end else if (state == SHIFT && phase_cnt == PH_LAST) begin
      shreg <= {shreg[13:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_s2p_link_controller.sv
// Bench for s2p_link_controller: vector table, directed corner sequences and a randomized
// run, all checked against a downstream shift-register model and a round-robin model.
module tb_s2p_link_controller;
  localparam int NUM_REQ     = 2;
  localparam int CLK_DIV     = 4;
  localparam int GAP_CYCLES  = 4;
  localparam int SYNC_CYCLES = 4;
  localparam int DW          = 15 * NUM_REQ;
  localparam int LATENCY     = 15 * CLK_DIV + CLK_DIV / 2;
  localparam int PERIOD      = 16 * CLK_DIV + GAP_CYCLES + 1;
  localparam int RWORDS      = 20;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_REQ-1:0] req_valid = '0;
  logic [DW-1:0]      req_data = '0;
  logic [NUM_REQ-1:0] req_ready;
  logic               serial_clock_out, serial_data_out, link_reset, busy, frame_done;
  logic [2:0]         grant_id;

  s2p_link_controller #(
    .NUM_REQ(NUM_REQ), .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .SYNC_CYCLES(SYNC_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .serial_clock_out(serial_clock_out),
    .serial_data_out(serial_data_out), .link_reset(link_reset), .busy(busy),
    .grant_id(grant_id), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  valid;
    logic [14:0] d0;
    logic [14:0] d1;
    logic [1:0]  exp_ready;
    int          exp_g;
    logic [14:0] exp_word;
  } vec_t;

  vec_t        tbl[8];
  int          checks = 0, errors = 0, cyc = 0;
  bit          prev_sclk = 1'b0, prev_sdata = 1'b0, wrap;
  int          ds_cnt = 0, rx_count = 0, fd_count = 0, total_edges = 0, frame_edges = 0;
  int          t_ready = 0, last_ready_cyc = -1, ready_gap = 0, m_ptr = 0;
  logic [14:0] ds_sh = '0, rx_word = '0;
  logic [14:0] exp_q[$];
  logic [14:0] rwords[NUM_REQ][RWORDS];
  int          head[NUM_REQ];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock: sample 1ns after the edge, advance downstream and arbitration models.
  task automatic step();
    int g_act, g_exp, j;
    @(posedge clock);
    #1;
    cyc++;
    wrap = 1'b0;
    if (reset) begin
      ds_cnt = 0; ds_sh = '0; m_ptr = 0; last_ready_cyc = -1;
      exp_q.delete();
    end else begin
      if (link_reset) begin
        ds_cnt = 0; ds_sh = '0;
      end else if (serial_clock_out && !prev_sclk) begin
        ds_sh = {ds_sh[13:0], serial_data_out};
        ds_cnt++; total_edges++; frame_edges++;
        if (ds_cnt == 16) begin
          ds_cnt = 0; wrap = 1'b1; rx_word = ds_sh; rx_count++;
        end
      end
      if (serial_clock_out)
        chk(serial_data_out == prev_sdata, "data_stable_high", int'(serial_data_out), int'(prev_sdata));
      if (req_ready != '0) begin
        g_act = -1;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g_act = i;
        g_exp = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          j = (m_ptr + k) % NUM_REQ;
          if (g_exp < 0 && req_valid[j]) g_exp = j;
        end
        chk($onehot(req_ready), "ready_onehot", int'(req_ready), 1);
        chk(g_act == g_exp, "rr_grant", g_act, g_exp);
        chk(int'(grant_id) == g_act, "grant_id", int'(grant_id), g_act);
        if (g_act >= 0) begin
          exp_q.push_back(req_data[15*g_act +: 15]);
          m_ptr = (g_act + 1) % NUM_REQ;
        end
        if (last_ready_cyc >= 0) ready_gap = cyc - last_ready_cyc;
        last_ready_cyc = cyc;
        t_ready = cyc;
        frame_edges = 0;
      end
      if (frame_done || wrap)
        chk(frame_done == wrap, "frame_done_align", int'(frame_done), int'(wrap));
      if (frame_done) begin
        fd_count++;
        chk(cyc - t_ready == LATENCY, "latency", cyc - t_ready, LATENCY);
        chk(frame_edges == 16, "edge_count", frame_edges, 16);
        if (exp_q.size() > 0) begin
          j = int'(exp_q.pop_front());
          chk(int'(rx_word) == j, "rx_word", int'(rx_word), j);
        end else begin
          chk(1'b0 == frame_done, "unexpected_frame", int'(rx_word), 0);
        end
      end
    end
    prev_sclk  = serial_clock_out;
    prev_sdata = serial_data_out;
  endtask

  task automatic wait_ready(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (req_ready != '0) begin ok = 1'b1; break; end
    end
    chk(ok, name, int'(ok), 1);
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (frame_done) begin ok = 1'b1; break; end
    end
    chk(ok, name, int'(ok), 1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (!busy) begin ok = 1'b1; break; end
    end
    chk(ok, name, int'(ok), 1);
  endtask

  task automatic chk_reset_values();
    chk(serial_clock_out == 1'b0, "rst_sclk", int'(serial_clock_out), 0);
    chk(serial_data_out == 1'b0, "rst_sdata", int'(serial_data_out), 0);
    chk(link_reset == 1'b1, "rst_link_reset", int'(link_reset), 1);
    chk(req_ready == '0, "rst_ready", int'(req_ready), 0);
    chk(busy == 1'b1, "rst_busy", int'(busy), 1);
    chk(grant_id == 3'd0, "rst_grant_id", int'(grant_id), 0);
    chk(frame_done == 1'b0, "rst_frame_done", int'(frame_done), 0);
  endtask

  // Called right after reset is released; link_reset must span SYNC_CYCLES cycles.
  task automatic chk_sync();
    int n = 1;
    chk(link_reset == 1'b1, "sync_start", int'(link_reset), 1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (!link_reset) break;
      n++;
    end
    chk(n == SYNC_CYCLES, "sync_len", n, SYNC_CYCLES);
    chk(busy == 1'b0, "idle_busy", int'(busy), 0);
  endtask

  initial begin
    int edges0, bad, rx0, fd0;
    bit done;
    tbl[0] = '{2'b01, 15'h5A3C, 15'h0000, 2'b01, 0, 15'h5A3C};
    tbl[1] = '{2'b11, 15'h0001, 15'h7FFF, 2'b10, 1, 15'h7FFF};
    tbl[2] = '{2'b11, 15'h0001, 15'h7FFF, 2'b01, 0, 15'h0001};
    tbl[3] = '{2'b10, 15'h0000, 15'h1234, 2'b10, 1, 15'h1234};
    tbl[4] = '{2'b10, 15'h0000, 15'h4321, 2'b10, 1, 15'h4321};
    tbl[5] = '{2'b11, 15'h0000, 15'h7FFF, 2'b01, 0, 15'h0000};
    tbl[6] = '{2'b01, 15'h7FFF, 15'h0000, 2'b01, 0, 15'h7FFF};
    tbl[7] = '{2'b11, 15'h2AAA, 15'h5555, 2'b10, 1, 15'h5555};

    // Reset, sync window, then quiet idle.
    repeat (3) step();
    chk_reset_values();
    reset = 1'b0;
    chk_sync();
    edges0 = total_edges;
    bad = 0;
    repeat (20) begin
      step();
      if (busy || req_ready != '0 || serial_clock_out) bad++;
    end
    chk(bad == 0, "idle_quiet", bad, 0);
    chk(total_edges == edges0, "idle_no_edges", total_edges - edges0, 0);

    // Vector table: one frame per entry, data scrambled after accept.
    for (int v = 0; v < 8; v++) begin
      req_data  = {tbl[v].d1, tbl[v].d0};
      req_valid = tbl[v].valid;
      wait_ready("tbl_ready_timeout");
      chk(req_ready == tbl[v].exp_ready, "tbl_ready", int'(req_ready), int'(tbl[v].exp_ready));
      chk(int'(grant_id) == tbl[v].exp_g, "tbl_grant", int'(grant_id), tbl[v].exp_g);
      req_valid = '0;
      req_data  = DW'($urandom());
      wait_done("tbl_done_timeout");
      chk(rx_word == tbl[v].exp_word, "tbl_word", int'(rx_word), int'(tbl[v].exp_word));
      wait_idle("tbl_idle_timeout");
      chk(int'(grant_id) == tbl[v].exp_g, "grant_hold", int'(grant_id), tbl[v].exp_g);
    end

    // Round-robin with both requesters valid continuously.
    req_data  = {15'h7FFF, 15'h0001};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ready("rr_timeout");
      chk(req_ready == (k[0] ? 2'b10 : 2'b01), "rr_order", int'(req_ready), k[0] ? 2 : 1);
      if (k > 0) chk(ready_gap == PERIOD, "rr_period", ready_gap, PERIOD);
    end
    req_valid = '0;
    wait_done("rr_done_timeout");
    wait_idle("rr_idle_timeout");

    // Fairness: after req1's lone grant, req0 goes next.
    req_data  = {15'h0F0F, 15'h3C3C};
    req_valid = 2'b10;
    wait_ready("fair_timeout1");
    chk(req_ready == 2'b10, "fair_first", int'(req_ready), 2);
    req_valid = 2'b11;
    wait_ready("fair_timeout2");
    chk(req_ready == 2'b01, "fair_second", int'(req_ready), 1);
    req_valid = '0;
    wait_done("fair_done_timeout");
    wait_idle("fair_idle_timeout");

    // Reset after 7 serial edges aborts the frame; next word arrives intact.
    req_data  = {15'h0000, 15'h2222};
    req_valid = 2'b01;
    wait_ready("abort_ready_timeout");
    req_valid = '0;
    for (int i = 0; i < 100 && frame_edges < 7; i++) step();
    chk(frame_edges == 7, "abort_edges", frame_edges, 7);
    rx0 = rx_count;
    fd0 = fd_count;
    reset = 1'b1;
    step();
    chk_reset_values();
    step();
    reset = 1'b0;
    chk_sync();
    chk(fd_count == fd0, "abort_no_done", fd_count - fd0, 0);
    chk(rx_count == rx0, "abort_no_word", rx_count - rx0, 0);
    req_data  = {15'h0000, 15'h1234};
    req_valid = 2'b01;
    wait_ready("post_abort_timeout");
    chk(int'(grant_id) == 0, "post_abort_grant", int'(grant_id), 0);
    req_valid = '0;
    wait_done("post_abort_done_timeout");
    chk(rx_word == 15'h1234, "post_abort_word", int'(rx_word), 'h1234);
    chk(rx_count == rx0 + 1, "post_abort_count", rx_count - rx0, 1);
    wait_idle("post_abort_idle_timeout");

    // Randomized traffic with valids that may drop before acceptance.
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      for (int w = 0; w < RWORDS; w++) rwords[i][w] = 15'($urandom());
    end
    rx0 = rx_count;
    done = 1'b0;
    for (int c = 0; c < 8000 && !done; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (head[i] < RWORDS) begin
          req_data[15*i +: 15] = rwords[i][head[i]];
          req_valid[i] = ($urandom_range(0, 3) != 0);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      step();
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) head[i]++;
      done = !busy && exp_q.size() == 0;
      for (int i = 0; i < NUM_REQ; i++) if (head[i] < RWORDS) done = 1'b0;
    end
    chk(done, "random_complete", int'(done), 1);
    chk(rx_count - rx0 == NUM_REQ * RWORDS, "random_frames", rx_count - rx0, NUM_REQ * RWORDS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
